instr_fetch_unit: RTL

//  Front end of the single-cycle MIPS-subset CPU: owns the PC, fetches each word

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: instruction constants and
// the fetch-unit state encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;

  // Fetch-unit control states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC computation: sequential step, or branch target
// pc + 4 + (sign-extended imm16 << 2). Arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm16,
  input  logic              PCSrc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] offset;

  // Sign-extend to full width before the shift so negative offsets stay negative.
  assign imm_sext = {{(ADDR_W-16){imm16[15]}}, imm16};
  assign offset   = imm_sext << 2;
  assign seq_pc   = pc + ADDR_W'(PC_STEP);

  // Select sequential or branch target.
  always_comb begin
    next_pc = seq_pc;
    if (PCSrc) next_pc = seq_pc + offset;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over
// a req/ack handshake and presents it for one ISSUE cycle, where the control
// unit decides next PC or halt.
// Optional feature: define RETIRE_CNT_EN to add a saturating retire counter.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               PCWre,
  input  logic               PCSrc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         Opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              started;
  logic              fetch_done;
  logic              issue_go;
  logic [ADDR_W-1:0] next_pc;

  // The cycle right after reset keeps the request low; fetching begins on the
  // first edge that sees reset released.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!Reset) started <= 1'b0;
    else        started <= 1'b1;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!Reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment on entry keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (fetch_done) state_nxt = ISSUE;
      ISSUE:   state_nxt = PCWre ? FETCH : HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH:   imem_req    = started;
      ISSUE:   instr_valid = 1'b1;
      HALT:    halted      = 1'b1;
      default: imem_req    = 1'b0;
    endcase
  end

  // Ack only counts while a request is actually outstanding.
  assign fetch_done = imem_req & imem_ack;
  assign issue_go   = (state == ISSUE) & PCWre;
  assign imem_addr  = pc;
  assign Opcode     = opcode_of(instr);

  // Instruction latch: captured only on a completed fetch.
  // NOTE: instr is a single register, not a memory, so it is cleared on reset
  // to give the documented reset value.
  always_ff @(posedge CLK) begin
    if (!Reset)          instr <= '0;
    else if (fetch_done) instr <= imem_rdata;
  end

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc      (pc),
    .imm16   (instr[15:0]),
    .PCSrc   (PCSrc),
    .next_pc (next_pc)
  );

  // PC register: advances only when an issued instruction does not halt.
  always_ff @(posedge CLK) begin
    if (!Reset)        pc <= RESET_PC;
    else if (issue_go) pc <= next_pc;
  end

`ifdef RETIRE_CNT_EN
  // Retired-instruction counter, saturating at all ones; halt is not counted.
  always_ff @(posedge CLK) begin
    if (!Reset)                          retire_cnt <= '0;
    else if (issue_go && retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule
